// File: rtl/dm_pkg.sv
// Shared types for the data memory: DMType codes, FSM encoding and the
// request legality check used at accept time.
package dm_pkg;

   localparam logic [2:0] DM_WORD   = 3'b000;
   localparam logic [2:0] DM_HALF   = 3'b001;
   localparam logic [2:0] DM_HALF_U = 3'b010;
   localparam logic [2:0] DM_BYTE   = 3'b011;
   localparam logic [2:0] DM_BYTE_U = 3'b100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dm_state_e;

   // Unsigned variants only make sense for loads; stores reject them.
   function automatic logic dm_illegal(input logic we, input logic [2:0] t,
                                       input logic [1:0] addr_lo);
      case (t)
         DM_WORD:   return addr_lo != 2'b00;
         DM_HALF:   return addr_lo[0];
         DM_HALF_U: return we | addr_lo[0];
         DM_BYTE:   return 1'b0;
         DM_BYTE_U: return we;
         default:   return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/dm_pipe_if.sv
// Request/response handshake bundle between the MEM-stage LSU (master)
// and the data memory (slave).
interface dm_pipe_if #(parameter int ADDR_WIDTH = 8);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [31:0]           req_wdata;
   logic [2:0]            req_type;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [31:0]           resp_rdata;
   logic                  resp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_type, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_type, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/dm_pipe_load_fmt.sv
// Load formatter: picks the low byte/half of a raw little-endian word and
// sign- or zero-extends it according to DMType.
module dm_load_fmt
   import dm_pkg::*;
(
   input  logic [31:0] raw,
   input  logic [2:0]  dm_type,
   output logic [31:0] data
);

   always_comb begin
      data = 32'h0;
      case (dm_type)
         DM_WORD:   data = raw;
         DM_HALF:   data = {{16{raw[15]}}, raw[15:0]};
         DM_HALF_U: data = {16'h0, raw[15:0]};
         DM_BYTE:   data = {{24{raw[7]}}, raw[7:0]};
         DM_BYTE_U: data = {24'h0, raw[7:0]};
         default:   data = 32'h0;
      endcase
   end

endmodule

// File: rtl/dm_pipe.sv
// Handshaked byte-addressable data memory, one access in flight, fixed
// read latency. Stores commit on the accept edge; loads snapshot raw bytes.
module dm_pipe
   import dm_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int RD_LATENCY = 1
) (
   input  logic     clk,
   input  logic     rstn,
   dm_pipe_if.slave bus
);

   localparam int         DEPTH    = 2 ** ADDR_WIDTH;
   localparam logic [1:0] CNT_INIT = 2'(RD_LATENCY - 1);

   // Array contents survive reset; only the zero power-up value is defined.
   logic [7:0] mem_q [DEPTH] = '{default: 8'h00};

   dm_state_e             state_q, state_d;
   logic [1:0]            cnt_q, cnt_d;
   logic                  we_q, we_d;
   logic                  err_q, err_d;
   logic [2:0]            type_q, type_d;
   logic [31:0]           raw_q, raw_d;
   logic                  accept;
   logic                  illegal;
   logic [ADDR_WIDTH-1:0] a0, a1, a2, a3;
   logic [31:0]           fmt_data;

   assign accept  = rstn && (state_q == IDLE) && bus.req_valid;
   assign illegal = dm_illegal(bus.req_we, bus.req_type, bus.req_addr[1:0]);
   assign a0      = bus.req_addr;
   assign a1      = bus.req_addr + ADDR_WIDTH'(1);
   assign a2      = bus.req_addr + ADDR_WIDTH'(2);
   assign a3      = bus.req_addr + ADDR_WIDTH'(3);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         type_q  <= DM_WORD;
         raw_q   <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         err_q   <= err_d;
         type_q  <= type_d;
         raw_q   <= raw_d;
      end
   end

   // Legal stores only; alignment guarantees a1..a3 never wrap for half/word.
   always_ff @(posedge clk) begin
      if (accept && bus.req_we && !illegal) begin
         mem_q[a0] <= bus.req_wdata[7:0];
         if (bus.req_type == DM_HALF || bus.req_type == DM_WORD)
            mem_q[a1] <= bus.req_wdata[15:8];
         if (bus.req_type == DM_WORD) begin
            mem_q[a2] <= bus.req_wdata[23:16];
            mem_q[a3] <= bus.req_wdata[31:24];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (bus.req_valid) begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
         end
         WAIT: if (cnt_q == 2'd0) state_d = RESP;
               else               cnt_d   = cnt_q - 2'd1;
         RESP: if (bus.resp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      we_d   = we_q;
      err_d  = err_q;
      type_d = type_q;
      raw_d  = raw_q;
      if (state_q == IDLE && bus.req_valid) begin
         we_d   = bus.req_we;
         err_d  = illegal;
         type_d = bus.req_type;
         raw_d  = {mem_q[a3], mem_q[a2], mem_q[a1], mem_q[a0]};
      end
   end

   dm_load_fmt u_fmt (
      .raw     (raw_q),
      .dm_type (type_q),
      .data    (fmt_data)
   );

   always_comb begin
      bus.req_ready  = (state_q == IDLE);
      bus.resp_valid = (state_q == RESP);
      bus.resp_err   = (state_q == RESP) && err_q;
      bus.resp_rdata = (state_q == RESP && !we_q && !err_q) ? fmt_data : 32'h0;
   end

endmodule
